bus_arbiter: RTL

Two-requester memory-bus arbiter that shares the single CPU-side address/data bus (BlockRAM at page 0xFF, LEDPanel I/O page) between the CPU6 port and a second master (debug loader / DMA). It runs a round-robin grant, drives the shared bus with registered outputs, and returns read data with a one-cycle acknowledge. Writes to unmapped pages are suppressed and flagged with an error. It sits between the masters and the existing BlockRAM/LEDPanel instances in the top-level.

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_if.sv | 31 +++
 rtl/bus_arbiter_rr_picker.sv | 14 +
 rtl/bus_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM encoding, default
// page constants and the page-decode helper.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] DEF_RAM_PAGE = 8'hFF;
   localparam logic [7:0] DEF_IO_PAGE  = 8'hF2;

   // A page is mapped when it hits either the BlockRAM or the LEDPanel page.
   function automatic logic is_mapped(input logic [15:0] addr,
                                      input logic [7:0]  ram_page,
                                      input logic [7:0]  io_page);
      return (addr[15:8] == ram_page) || (addr[15:8] == io_page);
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/ack handshake of both masters plus the shared target bus.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface bus_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [15:0] addr0;
   logic [15:0] addr1;
   logic [7:0]  wdata0;
   logic [7:0]  wdata1;
   logic        ack0;
   logic        ack1;
   logic        err0;
   logic        err1;
   logic [7:0]  rdata;
   logic [15:0] bus_addr;
   logic        bus_we;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata,
      output ack0, ack1, err0, err1, rdata, bus_addr, bus_we, bus_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata,
      input  ack0, ack1, err0, err1, rdata, bus_addr, bus_we, bus_wdata
   );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational two-way round-robin choice: on a tie the master that was
// not served last wins.
module rr_picker (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic valid,
   output logic winner
);

   assign valid  = req0 | req1;
   assign winner = (req0 && req1) ? ~last_owner : req1;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the BlockRAM/LEDPanel bus between CPU6 and a
// second master; every bus-side and handshake output comes from a flop.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter logic [7:0] RAM_PAGE = DEF_RAM_PAGE,
   parameter logic [7:0] IO_PAGE  = DEF_IO_PAGE
) (
   input  logic          clock,
   input  logic          reset,
   bus_arbiter_if.slave  bus
);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        err0_q, err0_d, err1_q, err1_d;

   logic        pick_valid;
   logic        pick_winner;
   logic [15:0] sel_addr;
   logic [7:0]  sel_wdata;
   logic        sel_we;
   logic        mapped;

   rr_picker u_picker (
      .req0       (bus.req0),
      .req1       (bus.req1),
      .last_owner (last_q),
      .valid      (pick_valid),
      .winner     (pick_winner)
   );

   assign sel_addr  = pick_winner ? bus.addr1  : bus.addr0;
   assign sel_wdata = pick_winner ? bus.wdata1 : bus.wdata0;
   assign sel_we    = pick_winner ? bus.we1    : bus.we0;
   assign mapped    = is_mapped(addr_q, RAM_PAGE, IO_PAGE);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_d    = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err0_d  = 1'b0;
      err1_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_winner;
               last_d  = pick_winner;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               // Unmapped writes never reach the targets.
               we_d    = sel_we && is_mapped(sel_addr, RAM_PAGE, IO_PAGE);
               state_d = BUSY;
            end
         end
         BUSY: begin
            rdata_d = mapped ? bus.bus_rdata : 8'h00;
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
            err0_d  = ~owner_q & ~mapped;
            err1_d  = owner_q & ~mapped;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= 16'h0000;
         wdata_q <= 8'h00;
         we_q    <= 1'b0;
         rdata_q <= 8'h00;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
      end
   end

   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_we    = we_q;
   assign bus.rdata     = rdata_q;
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.err0      = err0_q;
   assign bus.err1      = err1_q;

endmodule
